// File: rtl/mem_io_ctrl.sv
// LC-3 memory-side responder: MAR/MDR, external memory req/ack handshake,
// memory-mapped keyboard/display registers and the microsequencer ready flag.
module mem_io_ctrl #(
  parameter logic [15:0] IO_BASE   = 16'hFE00,
  parameter logic [15:0] KBSR_ADDR = 16'hFE00,
  parameter logic [15:0] KBDR_ADDR = 16'hFE02,
  parameter logic [15:0] DSR_ADDR  = 16'hFE04,
  parameter logic [15:0] DDR_ADDR  = 16'hFE06
) (
  input  logic        i_CLK,
  input  logic        i_Reset_n,
  input  logic        i_LD_MAR,
  input  logic        i_LD_MDR,
  input  logic        i_MIO_EN,
  input  logic        i_R_W,
  input  logic [15:0] i_Bus,
  output logic [15:0] o_MDR,
  output logic        o_R,
  output logic [15:0] o_Mem_Addr,
  output logic [15:0] o_Mem_WData,
  output logic        o_Mem_WE,
  output logic        o_Mem_Req,
  input  logic        i_Mem_Ack,
  input  logic [15:0] i_Mem_RData,
  input  logic        i_KB_Valid,
  input  logic [7:0]  i_KB_Data,
  input  logic        i_Disp_Ready,
  output logic        o_Disp_Valid,
  output logic [7:0]  o_Disp_Data,
  output logic        o_KB_IE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q;
  logic [15:0] mar_q, mdr_q, rdlat_q;
  logic        we_q;
  logic        r_q, req_q, mem_we_q, disp_valid_q;
  logic [7:0]  disp_data_q;
  logic        kb_rdy_q, kb_ie_q;
  logic [7:0]  kb_char_q;

  logic        start_s, is_io_s, kbdr_rd_s, kbsr_wr_s, ddr_wr_s;
  logic [15:0] io_rdata_s;

  // Access decode, evaluated against the MAR seen in IDLE
  always_comb begin
    start_s   = (state_q == S_IDLE) && i_MIO_EN;
    is_io_s   = (mar_q[15:8] == IO_BASE[15:8]);
    kbdr_rd_s = start_s && is_io_s && !i_R_W && (mar_q == KBDR_ADDR);
    kbsr_wr_s = start_s && is_io_s &&  i_R_W && (mar_q == KBSR_ADDR);
    ddr_wr_s  = start_s && is_io_s &&  i_R_W && (mar_q == DDR_ADDR);
  end

  // I/O register read mux
  always_comb begin
    case (mar_q)
      KBSR_ADDR: io_rdata_s = {kb_rdy_q, kb_ie_q, 14'b0};
      KBDR_ADDR: io_rdata_s = {8'b0, kb_char_q};
      DSR_ADDR:  io_rdata_s = {i_Disp_Ready, 15'b0};
      default:   io_rdata_s = 16'h0000;
    endcase
  end

  // MAR and MDR registers
  always_ff @(posedge i_CLK or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      mar_q <= 16'h0000;
      mdr_q <= 16'h0000;
    end else begin
      if (i_LD_MAR) mar_q <= i_Bus;
      if (i_LD_MDR) mdr_q <= (i_MIO_EN && !i_R_W) ? rdlat_q : i_Bus;
    end
  end

  // Access FSM with registered strobes; strobes default low so they pulse
  always_ff @(posedge i_CLK or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q      <= S_IDLE;
      rdlat_q      <= 16'h0000;
      we_q         <= 1'b0;
      r_q          <= 1'b0;
      req_q        <= 1'b0;
      mem_we_q     <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= 8'h00;
    end else begin
      r_q          <= 1'b0;
      req_q        <= 1'b0;
      mem_we_q     <= 1'b0;
      disp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_MIO_EN) begin
            we_q <= i_R_W;
            if (is_io_s) begin
              state_q <= S_DONE;
              r_q     <= 1'b1;
              if (!i_R_W) rdlat_q <= io_rdata_s;
              if (ddr_wr_s) begin
                disp_valid_q <= 1'b1;
                disp_data_q  <= mdr_q[7:0];
              end
            end else begin
              state_q  <= S_REQ;
              req_q    <= 1'b1;
              mem_we_q <= i_R_W;
            end
          end
        end
        S_REQ:  state_q <= S_WAIT;
        S_WAIT: begin
          if (i_Mem_Ack) begin
            state_q <= S_DONE;
            r_q     <= 1'b1;
            if (!we_q) rdlat_q <= i_Mem_RData;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Keyboard registers; a new character wins over a same-edge KBDR read clear
  always_ff @(posedge i_CLK or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      kb_rdy_q  <= 1'b0;
      kb_ie_q   <= 1'b0;
      kb_char_q <= 8'h00;
    end else begin
      if (i_KB_Valid) begin
        kb_rdy_q  <= 1'b1;
        kb_char_q <= i_KB_Data;
      end else if (kbdr_rd_s) begin
        kb_rdy_q <= 1'b0;
      end
      if (kbsr_wr_s) kb_ie_q <= mdr_q[14];
    end
  end

  assign o_MDR        = mdr_q;
  assign o_R          = r_q;
  assign o_Mem_Addr   = mar_q;
  assign o_Mem_WData  = mdr_q;
  assign o_Mem_WE     = mem_we_q;
  assign o_Mem_Req    = req_q;
  assign o_Disp_Valid = disp_valid_q;
  assign o_Disp_Data  = disp_data_q;
  assign o_KB_IE      = kb_ie_q;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Randomized bench for mem_io_ctrl against a transaction-level model of
// memory contents and the keyboard/display register state.
module tb_mem_io_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_mar, ld_mdr, mio_en, r_w;
  logic [15:0] bus;
  logic [15:0] mdr, mem_addr, mem_wdata, mem_rdata;
  logic        r, mem_we, mem_req, mem_ack;
  logic        kb_valid, disp_ready, disp_valid, kb_ie;
  logic [7:0]  kb_data, disp_data;

  mem_io_ctrl dut (
    .i_CLK(clk), .i_Reset_n(rst_n), .i_LD_MAR(ld_mar), .i_LD_MDR(ld_mdr),
    .i_MIO_EN(mio_en), .i_R_W(r_w), .i_Bus(bus), .o_MDR(mdr), .o_R(r),
    .o_Mem_Addr(mem_addr), .o_Mem_WData(mem_wdata), .o_Mem_WE(mem_we),
    .o_Mem_Req(mem_req), .i_Mem_Ack(mem_ack), .i_Mem_RData(mem_rdata),
    .i_KB_Valid(kb_valid), .i_KB_Data(kb_data), .i_Disp_Ready(disp_ready),
    .o_Disp_Valid(disp_valid), .o_Disp_Data(disp_data), .o_KB_IE(kb_ie)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [15:0] ref_mem [logic [15:0]];
  logic        m_kb_ready, m_kb_ie;
  logic [7:0]  m_kb_char;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic get_mem(input logic [15:0] a, output logic [15:0] v);
    if (!ref_mem.exists(a)) ref_mem[a] = 16'($urandom);
    v = ref_mem[a];
  endtask

  task automatic model_reset();
    m_kb_ready = 1'b0;
    m_kb_ie    = 1'b0;
    m_kb_char  = 8'h00;
  endtask

  task automatic kb_strobe(input logic [7:0] ch);
    @(negedge clk);
    kb_valid = 1'b1;
    kb_data  = ch;
    @(negedge clk);
    kb_valid = 1'b0;
    m_kb_ready = 1'b1;
    m_kb_char  = ch;
  endtask

  // One complete access as the control store would issue it
  task automatic access(input logic [15:0] addr, input logic we, input logic [15:0] data,
                        input int dly, input logic kb_same, input logic [7:0] kb_ch);
    logic        io, exp_disp;
    logic [15:0] exp_rd;
    logic [7:0]  disp_seen;
    int          lat, reqs, disps;
    io = (addr[15:8] == 8'hFE);
    if (io) begin
      case (addr)
        16'hFE00: exp_rd = {m_kb_ready, m_kb_ie, 14'b0};
        16'hFE02: exp_rd = {8'h00, m_kb_char};
        16'hFE04: exp_rd = {disp_ready, 15'b0};
        default:  exp_rd = 16'h0000;
      endcase
    end else begin
      get_mem(addr, exp_rd);
    end
    exp_disp = io && we && (addr == 16'hFE06);

    @(negedge clk);
    ld_mar = 1'b1;
    bus    = addr;
    if (we) begin
      @(negedge clk);
      ld_mar = 1'b0;
      ld_mdr = 1'b1;
      bus    = data;
    end
    @(negedge clk);
    ld_mar = 1'b0;
    ld_mdr = 1'b0;
    bus    = 16'($urandom);
    mio_en = 1'b1;
    r_w    = we;
    if (kb_same) begin
      kb_valid = 1'b1;
      kb_data  = kb_ch;
    end
    @(negedge clk);
    mio_en   = 1'b0;
    r_w      = ~we;
    kb_valid = 1'b0;
    if (io && !we && addr == 16'hFE02) m_kb_ready = 1'b0;
    if (io && we && addr == 16'hFE00) m_kb_ie = data[14];
    if (kb_same) begin
      m_kb_ready = 1'b1;
      m_kb_char  = kb_ch;
    end
    if (!io && we) ref_mem[addr] = data;

    lat = 0; reqs = 0; disps = 0; disp_seen = 8'h00;
    for (int c = 1; c <= 40; c++) begin
      if (mem_req) begin
        reqs++;
        check("req_we", mem_we, we);
        check("req_addr", mem_addr, addr);
        if (we) check("req_wdata", mem_wdata, data);
      end
      if (disp_valid) begin
        disps++;
        disp_seen = disp_data;
      end
      if (r) begin
        lat = c;
        break;
      end
      mem_ack   = !io && (c == 2 + dly);
      mem_rdata = mem_ack ? exp_rd : 16'($urandom);
      @(negedge clk);
    end
    mem_ack = 1'b0;
    check("latency", lat, io ? 1 : 3 + dly);
    check("req_count", reqs, io ? 0 : 1);
    check("disp_count", disps, exp_disp);
    if (exp_disp) check("disp_data", disp_seen, data[7:0]);

    if (!we) begin
      mio_en = 1'b1;
      r_w    = 1'b0;
      ld_mdr = 1'b1;
    end
    @(negedge clk);
    mio_en = 1'b0;
    ld_mdr = 1'b0;
    r_w    = 1'b0;
    check("r_pulse", r, 1'b0);
    check("disp_off", disp_valid, 1'b0);
    check("mdr", mdr, we ? data : exp_rd);
    check("kb_ie", kb_ie, m_kb_ie);
  endtask

  logic [15:0] a, d;
  int          hits;

  initial begin
    rst_n = 1'b0; ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b0; r_w = 1'b0;
    bus = 16'h0000; mem_ack = 1'b0; mem_rdata = 16'h0000; kb_valid = 1'b0;
    kb_data = 8'h00; disp_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // asynchronous reset with MAR/MDR loaded
    @(negedge clk); ld_mar = 1'b1; bus = 16'h3000;
    @(negedge clk); ld_mar = 1'b0; ld_mdr = 1'b1; bus = 16'h1111;
    @(negedge clk); ld_mdr = 1'b0;
    check("mar_loaded", mem_addr, 16'h3000);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mar", mem_addr, 16'h0000);
    check("rst_mdr", mdr, 16'h0000);
    check("rst_r", r, 1'b0);
    check("rst_req", mem_req, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // directed memory read and write
    ref_mem[16'h3000] = 16'h1234;
    access(16'h3000, 1'b0, 16'h0000, 1, 1'b0, 8'h00);
    access(16'h4000, 1'b1, 16'hBEEF, 0, 1'b0, 8'h00);

    // keyboard, including a strobe on the KBDR-read edge
    kb_strobe(8'h41);
    access(16'hFE00, 1'b0, 16'h0000, 0, 1'b0, 8'h00);
    access(16'hFE02, 1'b0, 16'h0000, 0, 1'b0, 8'h00);
    access(16'hFE00, 1'b0, 16'h0000, 0, 1'b0, 8'h00);
    kb_strobe(8'h41);
    access(16'hFE02, 1'b0, 16'h0000, 0, 1'b1, 8'h42);
    access(16'hFE00, 1'b0, 16'h0000, 0, 1'b0, 8'h00);
    access(16'hFE02, 1'b0, 16'h0000, 0, 1'b0, 8'h00);

    // display and KBSR write
    access(16'hFE06, 1'b1, 16'h0058, 0, 1'b0, 8'h00);
    disp_ready = 1'b1;
    access(16'hFE04, 1'b0, 16'h0000, 0, 1'b0, 8'h00);
    access(16'hFE00, 1'b1, 16'hFFFF, 0, 1'b0, 8'h00);
    access(16'hFE00, 1'b0, 16'h0000, 0, 1'b0, 8'h00);

    // reset in WAIT, then late ack and spurious acks in IDLE
    @(negedge clk); ld_mar = 1'b1; bus = 16'h5000;
    @(negedge clk); ld_mar = 1'b0; mio_en = 1'b1; r_w = 1'b0;
    @(negedge clk); mio_en = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("wait_rst_req", mem_req, 1'b0);
    check("wait_rst_ie", kb_ie, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    hits = 0;
    for (int c = 0; c < 6; c++) begin
      mem_ack   = (c == 0 || c == 3);
      mem_rdata = 16'hDEAD;
      @(negedge clk);
      if (r || mem_req) hits++;
    end
    mem_ack = 1'b0;
    check("late_ack_ignored", hits, 0);
    check("late_ack_mdr", mdr, 16'h0000);

    // randomized mix of memory and I/O accesses
    for (int i = 0; i < 60; i++) begin
      disp_ready = 1'($urandom);
      if ($urandom_range(0, 3) == 0) kb_strobe(8'($urandom));
      if ($urandom_range(0, 1) == 0) begin
        a = 16'($urandom);
        if (a[15:8] == 8'hFE) a[8] = 1'b1;
        access(a, 1'($urandom), 16'($urandom), $urandom_range(0, 3), 1'b0, 8'h00);
      end else begin
        case ($urandom_range(0, 4))
          0:       a = 16'hFE00;
          1:       a = 16'hFE02;
          2:       a = 16'hFE04;
          3:       a = 16'hFE06;
          default: a = {8'hFE, 8'($urandom)};
        endcase
        d = 16'($urandom);
        access(a, 1'($urandom), d, 0, ($urandom_range(0, 3) == 0), 8'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_io_ctrl.md
Name: mem_io_ctrl

Overview:
- Memory-side responder for the LC-3 datapath. Holds MAR and MDR.
- Serves the fetch and load/store accesses issued by the control store and PC logic: reads and writes external memory with a req/ack handshake, and decodes the memory-mapped I/O registers KBSR, KBDR, DSR and DDR.
- Raises the ready flag R that the microsequencer waits on.

Parameters:
IO_BASE, 16'hFE00, base address of the I/O page; any address with [15:8] == IO_BASE[15:8] is I/O and never reaches external memory
KBSR_ADDR, 16'hFE00, keyboard status register address
KBDR_ADDR, 16'hFE02, keyboard data register address
DSR_ADDR, 16'hFE04, display status register address
DDR_ADDR, 16'hFE06, display data register address

Ports:
i_CLK  in  1  system clock; all state updates on rising edge
i_Reset_n  in  1  asynchronous, active-low reset
i_LD_MAR  in  1  load MAR from i_Bus
i_LD_MDR  in  1  load MDR (source selected by i_MIO_EN/i_R_W)
i_MIO_EN  in  1  memory/I/O access request from control store
i_R_W  in  1  0 = read, 1 = write
i_Bus  in  16  global bus
o_MDR  out  16  MDR contents (to bus via GateMDR)
o_R  out  1  access complete, one-cycle pulse
o_Mem_Addr  out  16  external memory address (= MAR)
o_Mem_WData  out  16  external write data (= MDR)
o_Mem_WE  out  1  write enable, valid with o_Mem_Req
o_Mem_Req  out  1  one-cycle request pulse
i_Mem_Ack  in  1  memory completion pulse
i_Mem_RData  in  16  read data, valid with i_Mem_Ack
i_KB_Valid  in  1  keyboard character strobe
i_KB_Data  in  8  keyboard character
i_Disp_Ready  in  1  display can accept a character
o_Disp_Valid  out  1  one-cycle display write strobe
o_Disp_Data  out  8  character to display
o_KB_IE  out  1  KBSR[14], keyboard interrupt enable

Behaviour:
- Reset (i_Reset_n = 0, asynchronous): MAR, MDR and the internal read latch reset to 0. o_R, o_Mem_Req, o_Mem_WE and o_Disp_Valid reset to 0. KBSR and KBDR reset to 0. FSM returns to IDLE. Reset mid-access abandons the access; a later i_Mem_Ack arriving in IDLE is ignored.
- MAR: i_LD_MAR -> MAR <= i_Bus.
- MDR on i_LD_MDR:
  - If i_MIO_EN = 1 and i_R_W = 0: MDR <= read latch. Valid only in the DONE cycle; the control store asserts LD_MDR there.
  - Otherwise: MDR <= i_Bus.
- FSM states IDLE, REQ, WAIT, DONE. The access is sampled in IDLE from MAR, MDR and i_R_W.
  - IDLE + i_MIO_EN, MAR not in I/O page -> REQ.
  - IDLE + i_MIO_EN, MAR in I/O page -> DONE. I/O read data is latched on this edge.
  - REQ: o_Mem_Req = 1, o_Mem_WE = i_R_W latched at start -> WAIT.
  - WAIT: stay until i_Mem_Ack. On ack, read latch <= i_Mem_RData (reads only) -> DONE. i_Mem_Ack is ignored in any state except WAIT.
  - DONE: o_R = 1 for exactly one cycle -> IDLE.
  - An access is not restarted from DONE. A new access needs i_MIO_EN seen again in IDLE, so back-to-back accesses have a minimum of one idle cycle.
- Latency, i_MIO_EN rising to o_R:
  - I/O: 1 cycle.
  - Memory: 3 cycles when ack comes in the first WAIT cycle, plus one cycle per extra wait cycle.
- i_MIO_EN dropped after IDLE: the access still completes and o_R still pulses.
- o_Mem_Addr = MAR, o_Mem_WData = MDR at all times; they are only meaningful while o_Mem_Req = 1.
- I/O reads (16-bit results):
  - KBSR: {ready, IE, 14'b0}.
  - KBDR: {8'b0, char}. Clears KBSR[15] on the completing edge.
  - DSR: {i_Disp_Ready, 15'b0}.
  - DDR and other I/O-page addresses: 0.
- I/O writes:
  - KBSR: only bit 14 is written (IE).
  - DDR: o_Disp_Valid = 1 for one cycle with o_Disp_Data = MDR[7:0], in the DONE cycle. Software is responsible for polling DSR; the block does not check ready.
  - All others: ignored.
- Keyboard: i_KB_Valid -> KBDR <= i_KB_Data, KBSR[15] <= 1. This overwrites an unread character.
  - i_KB_Valid on the same edge as a KBDR read clear: set wins. KBSR[15] stays 1 and KBDR takes the new character; the read returns the old character.
- Width: all address and data paths are 16-bit; no arithmetic.

Test Plan:
- Reset with MAR = 16'h3000 loaded -> MAR = 0, MDR = 0, o_R = 0, o_Mem_Req = 0 immediately, without waiting for a clock edge.
- Read MAR = 16'h3000, memory acks 2 cycles after req with 16'h1234 -> single o_Mem_Req with WE = 0, o_R one cycle after ack, LD_MDR in DONE -> o_MDR = 16'h1234.
- Write MAR = 16'h4000, MDR = 16'hBEEF -> o_Mem_Req with WE = 1, Addr 16'h4000, WData 16'hBEEF; o_R after ack; MDR unchanged.
- Keyboard: i_KB_Data = 8'h41 strobe; read KBSR -> MDR = 16'h8000 after 1-cycle o_R; read KBDR -> MDR = 16'h0041; KBSR[15] = 0 afterwards. Repeat with a strobe of 8'h42 on the KBDR-read edge -> MDR = 16'h0041, KBSR[15] stays 1, KBDR = 16'h0042.
- Write DDR with MDR = 16'h0058 -> o_Disp_Valid pulse with o_Disp_Data = 8'h58, no o_Mem_Req. Read DSR with i_Disp_Ready = 1 -> 16'h8000. Write KBSR = 16'hFFFF -> o_KB_IE = 1, KBSR[15] unchanged.
- Reset asserted in WAIT, ack arrives after release -> FSM stays IDLE, no o_R. Spurious i_Mem_Ack in IDLE -> no effect.
